// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg
//  Shared constants and types for the 16-channel TDM demultiplexer.
//  N_CH  : channels per frame (fixed at 16)
//  SEL_W : width of a channel/slot index
//  state_t : frame-alignment FSM states
package tdm_demux_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux16_if.sv
// tdm_demux16_if
//  Bundles the stream input and parallel output signals of tdm_demux16.
//  master : the stream source / consumer side (drives mode, sel, din, din_valid, frame_sync)
//  slave  : the demultiplexer itself (drives y, y_strobe, y_frame, frame_done, slot,
//           locked, sync_err)
interface tdm_demux16_if;
    import tdm_demux_pkg::*;

    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             din;
    logic             din_valid;
    logic             frame_sync;
    logic [N_CH-1:0]  y;
    logic [N_CH-1:0]  y_strobe;
    logic [N_CH-1:0]  y_frame;
    logic             frame_done;
    logic [SEL_W-1:0] slot;
    logic             locked;
    logic             sync_err;

    modport master (
        output mode, sel, din, din_valid, frame_sync,
        input  y, y_strobe, y_frame, frame_done, slot, locked, sync_err
    );

    modport slave (
        input  mode, sel, din, din_valid, frame_sync,
        output y, y_strobe, y_frame, frame_done, slot, locked, sync_err
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter
//  Slot counter for the TDM demultiplexer.
//  clk       : clock
//  rst_n     : synchronous reset, active low (count -> 0)
//  clr       : force count to 0
//  load1     : force count to 1 (slot 0 has just been written)
//  inc       : advance count, wrapping 15 -> 0
//  count     : next slot to be written
//  last_slot : count is at the final slot of a frame
// Priority: reset, clr, load1, inc.
module tdm_slot_counter
    import tdm_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] count,
    output logic             last_slot
);

    logic [SEL_W-1:0] count_reg;
    logic [SEL_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (load1) begin
            count_next = SEL_W'(1);
        end else if (inc) begin
            // natural 4-bit overflow provides the 15 -> 0 wrap
            count_next = count_reg + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count     = count_reg;
    assign last_slot = (count_reg == SEL_W'(N_CH - 1));

endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16
//  Routes a 1-bit qualified stream onto 16 registered channel outputs.
//  Auto mode (mode=0) aligns to frame_sync and unpacks 16-slot frames, publishing each
//  complete frame on y_frame; direct mode (mode=1) writes each valid bit to channel sel.
//  clk   : clock
//  rst_n : synchronous reset, active low
//  bus   : slave modport of tdm_demux16_if
//          inputs  mode, sel, din, din_valid, frame_sync
//          outputs y, y_strobe, y_frame, frame_done, slot, locked, sync_err
//  All outputs are registered; a bit sampled at one edge is visible after that edge.
module tdm_demux16
    import tdm_demux_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux16_if.slave bus
);

    state_t           state_reg, state_next;
    logic [N_CH-1:0]  y_reg, y_next;
    logic [N_CH-1:0]  strobe_reg, strobe_next;
    logic [N_CH-1:0]  shadow_reg, shadow_next;
    logic [N_CH-1:0]  y_frame_reg, y_frame_next;
    logic             frame_done_reg, frame_done_next;
    logic             sync_err_reg, sync_err_next;

    logic             cnt_clr, cnt_load1, cnt_inc;
    logic [SEL_W-1:0] slot_cnt;
    logic             last_slot;

    // Single channel write per cycle: enable plus index, decoded below.
    logic             wr_en;
    logic [SEL_W-1:0] wr_idx;
    logic [N_CH-1:0]  wr_oh;

    tdm_slot_counter u_slot_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .load1     (cnt_load1),
        .inc       (cnt_inc),
        .count     (slot_cnt),
        .last_slot (last_slot)
    );

    always_comb begin
        state_next      = state_reg;
        shadow_next     = shadow_reg;
        y_frame_next    = y_frame_reg;
        frame_done_next = 1'b0;
        sync_err_next   = 1'b0;
        cnt_clr         = 1'b0;
        cnt_load1       = 1'b0;
        cnt_inc         = 1'b0;
        wr_en           = 1'b0;
        wr_idx          = '0;

        if (bus.mode) begin
            // Direct mode holds the aligner idle; leaving it therefore always restarts
            // in HUNT with an empty shadow, which also covers any mode toggle.
            state_next  = HUNT;
            cnt_clr     = 1'b1;
            shadow_next = '0;
            wr_en       = bus.din_valid;
            wr_idx      = bus.sel;
        end else if (bus.din_valid) begin
            if (bus.frame_sync) begin
                // Start of frame, from HUNT or LOCKED. A sync that lands mid-frame
                // abandons the partial frame; y_frame is left alone.
                sync_err_next  = (state_reg == LOCKED) && (slot_cnt != '0);
                state_next     = LOCKED;
                cnt_load1      = 1'b1;
                wr_en          = 1'b1;
                wr_idx         = '0;
                shadow_next    = '0;
                shadow_next[0] = bus.din;
            end else if (state_reg == LOCKED) begin
                wr_en  = 1'b1;
                wr_idx = slot_cnt;
                cnt_inc = 1'b1;
                if (last_slot) begin
                    frame_done_next = 1'b1;
                    y_frame_next    = {bus.din, shadow_reg[N_CH-2:0]};
                    shadow_next     = '0;
                end else begin
                    shadow_next[slot_cnt] = bus.din;
                end
            end
            // HUNT without frame_sync: bit dropped
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            assign wr_oh[gi]       = wr_en && (wr_idx == SEL_W'(gi));
            assign y_next[gi]      = wr_oh[gi] ? bus.din : y_reg[gi];
            assign strobe_next[gi] = wr_oh[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= HUNT;
            y_reg          <= '0;
            strobe_reg     <= '0;
            shadow_reg     <= '0;
            y_frame_reg    <= '0;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            y_reg          <= y_next;
            strobe_reg     <= strobe_next;
            shadow_reg     <= shadow_next;
            y_frame_reg    <= y_frame_next;
            frame_done_reg <= frame_done_next;
            sync_err_reg   <= sync_err_next;
        end
    end

    assign bus.y          = y_reg;
    assign bus.y_strobe   = strobe_reg;
    assign bus.y_frame    = y_frame_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.slot       = slot_cnt;
    assign bus.locked     = (state_reg == LOCKED);
    assign bus.sync_err   = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16
//  Self-checking bench for tdm_demux16. A behavioural model tracks channel values,
//  the frame in progress and alignment as plain variables; every cycle's outputs are
//  compared against it, plus directed checks on the documented scenarios.
module tb_tdm_demux16;
    import tdm_demux_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tdm_demux16_if bus ();

    tdm_demux16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [15:0] m_y, m_strobe, m_frame, m_partial;
    bit        m_fd, m_se, m_locked;
    int        m_pos;   // next slot of the frame in progress

    task automatic model_step(input bit rst, input bit md, input bit [3:0] s,
                              input bit d, input bit v, input bit fs);
        m_strobe = '0;
        m_fd     = 1'b0;
        m_se     = 1'b0;
        if (rst) begin
            m_y = '0; m_frame = '0; m_partial = '0; m_locked = 0; m_pos = 0;
        end else if (md) begin
            m_locked = 0; m_pos = 0; m_partial = '0;
            if (v) begin
                m_y[s]   = d;
                m_strobe = 16'd1 << s;
            end
        end else if (v && fs) begin
            m_se       = m_locked && (m_pos != 0);
            m_locked   = 1;
            m_partial  = {15'd0, d};
            m_y[0]     = d;
            m_strobe   = 16'd1;
            m_pos      = 1;
        end else if (v && m_locked) begin
            m_y[m_pos]       = d;
            m_strobe         = 16'd1 << m_pos;
            m_partial[m_pos] = d;
            if (m_pos == 15) begin
                m_frame   = m_partial;
                m_fd      = 1'b1;
                m_partial = '0;
                m_pos     = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    function automatic logic [54:0] observed();
        return {bus.y, bus.y_strobe, bus.y_frame, bus.frame_done, bus.slot,
                bus.locked, bus.sync_err};
    endfunction

    function automatic logic [54:0] expected();
        logic [3:0] sl;
        sl = 4'(m_pos);
        return {m_y, m_strobe, m_frame, m_fd, sl, m_locked, m_se};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic cyc(input bit rst, input bit md, input bit [3:0] s,
                       input bit d, input bit v, input bit fs);
        rst_n          = ~rst;
        bus.mode       = md;
        bus.sel        = s;
        bus.din        = d;
        bus.din_valid  = v;
        bus.frame_sync = fs;
        @(posedge clk);
        model_step(rst, md, s, d, v, fs);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cyc(1, 0, 0, 1, 1, 1);
        cyc(1, 0, 0, 1, 1, 1);
        checks++;
        if (observed() !== 55'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", observed());
        end
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_locked got=%b want=0", bus.locked);
        end
    endtask

    task automatic test_direct();
        cyc(0, 1, 6, 1, 1, 0);
        checks++;
        if (bus.y !== 16'h0040 || bus.y_strobe !== 16'h0040) begin
            errors++;
            $display("FAIL direct_sel6 got y=%h strobe=%h want 0040/0040", bus.y, bus.y_strobe);
        end
        cyc(0, 1, 15, 1, 1, 0);
        checks++;
        if (bus.y !== 16'h8040 || bus.y_strobe !== 16'h8000 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL direct_sel15 got y=%h strobe=%h locked=%b want 8040/8000/0",
                     bus.y, bus.y_strobe, bus.locked);
        end
        for (int i = 0; i < 24; i++) begin
            cyc(0, 1, 4'($urandom_range(15)), 1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL direct_rand[%0d] got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_auto_frame();
        logic [15:0] w;
        w = 16'h5441;
        cyc(0, 0, 0, 0, 0, 0);   // idle cycle in auto mode
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 4'($urandom), w[i], 1, i == 0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL auto_bit[%0d] got=%h want=%h", i, observed(), expected());
            end
        end
        checks++;
        if (bus.frame_done !== 1'b1 || bus.y_frame !== 16'h5441 || bus.slot !== 4'd0 ||
            bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL auto_frame got fd=%b y_frame=%h slot=%0d locked=%b want 1/5441/0/1",
                     bus.frame_done, bus.y_frame, bus.slot, bus.locked);
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.frame_done !== 1'b0 || bus.y_strobe !== 16'h0) begin
            errors++;
            $display("FAIL auto_pulse got fd=%b strobe=%h want 0/0000", bus.frame_done, bus.y_strobe);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] w;
        w = 16'h5441;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, w[i], 1, i == 0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL gaps_bit[%0d] got=%h want=%h", i, observed(), expected());
            end
            if (i == 4 || i == 11) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(0, 0, 0, 1'($urandom), 0, 1'($urandom));
                    checks++;
                    if (bus.y_strobe !== 16'h0 || bus.slot !== 4'(i + 1) || bus.frame_done !== 1'b0) begin
                        errors++;
                        $display("FAIL gaps_hold[%0d.%0d] got strobe=%h slot=%0d fd=%b want 0000/%0d/0",
                                 i, g, bus.y_strobe, bus.slot, bus.frame_done, i + 1);
                    end
                end
            end
        end
        checks++;
        if (bus.frame_done !== 1'b1 || bus.y_frame !== 16'h5441) begin
            errors++;
            $display("FAIL gaps_frame got fd=%b y_frame=%h want 1/5441", bus.frame_done, bus.y_frame);
        end
    endtask

    task automatic test_early_sync();
        logic [15:0] w;
        w = 16'hA5C3;
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1'($urandom), 1, i == 0);
        // sync arrives with bit 6 of the old frame: it becomes slot 0 of 16'hA5C3
        cyc(0, 0, 0, w[0], 1, 1);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.y_strobe !== 16'h0001 || bus.slot !== 4'd1 ||
            bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL early_sync got se=%b strobe=%h slot=%0d fd=%b want 1/0001/1/0",
                     bus.sync_err, bus.y_strobe, bus.slot, bus.frame_done);
        end
        for (int i = 1; i < 16; i++) begin
            cyc(0, 0, 0, w[i], 1, 0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL early_bit[%0d] got=%h want=%h", i, observed(), expected());
            end
        end
        checks++;
        if (bus.y_frame !== 16'hA5C3 || bus.frame_done !== 1'b1 || bus.sync_err !== 1'b0) begin
            errors++;
            $display("FAIL early_frame got y_frame=%h fd=%b se=%b want A5C3/1/0",
                     bus.y_frame, bus.frame_done, bus.sync_err);
        end
    endtask

    task automatic test_disruption();
        logic [15:0] keep_frame, keep_y;
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1'($urandom), 1, i == 0);
        cyc(1, 0, 0, 1, 1, 1);
        checks++;
        if (observed() !== 55'd0) begin
            errors++;
            $display("FAIL disrupt_reset got=%h want=0", observed());
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1'($urandom), 1, 0);
            checks++;
            if (bus.y_strobe !== 16'h0 || bus.locked !== 1'b0 || observed() !== expected()) begin
                errors++;
                $display("FAIL disrupt_hunt[%0d] got=%h want=%h", i, observed(), expected());
            end
        end
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1'($urandom), 1, i == 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1'($urandom), 1, i == 0);
        keep_frame = bus.y_frame;
        keep_y     = bus.y;
        cyc(0, 1, 0, 0, 0, 0);   // mode toggle, no data
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.locked !== 1'b0 || bus.slot !== 4'd0 || bus.y !== keep_y ||
            bus.y_frame !== keep_frame || observed() !== expected()) begin
            errors++;
            $display("FAIL disrupt_mode got=%h want=%h", observed(), expected());
        end
    endtask

    task automatic test_random();
        bit md, v, fs;
        for (int i = 0; i < 600; i++) begin
            md = ($urandom_range(19) == 0);
            v  = ($urandom_range(3) != 0);
            fs = ($urandom_range(24) == 0) || (!m_locked && $urandom_range(3) == 0);
            cyc($urandom_range(199) == 0, md, 4'($urandom), 1'($urandom), v, fs);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random[%0d] got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.mode = 1'b0; bus.sel = '0; bus.din = 1'b0;
        bus.din_valid = 1'b0; bus.frame_sync = 1'b0;
        m_y = '0; m_strobe = '0; m_frame = '0; m_partial = '0;
        m_fd = 0; m_se = 0; m_locked = 0; m_pos = 0;
        #2;
        test_reset();
        test_direct();
        test_auto_frame();
        test_gaps();
        test_early_sync();
        test_disruption();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
